// File: rtl/seq_gen_pkg.sv
// seq_gen_pkg -- shared types and defaults for the serial pattern generator.
//
// Contents:
//   PAT_W_DEF / REP_W_DEF : default pattern width and repetition-count width
//   state_t               : generator FSM state encoding
//
// Configuration macro: SEQ_GEN_GAP_EN -- when defined, the GAP state exists
// and one idle bit slot separates consecutive repetitions. When undefined the
// state is not declared at all and repetitions run back-to-back.

package seq_gen_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int REP_W_DEF = 4;

`ifdef SEQ_GEN_GAP_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd3
  } state_t;
`endif

endpackage

// File: rtl/seq_shift_reg.sv
// seq_shift_reg -- loadable pattern register with an indexed bit tap.
//
// The generator never physically shifts the pattern; it holds it still and
// walks a bit index downwards, which makes MSB-first order of a variable-length
// field trivial.
//
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset, clears the register
//   load     in   capture din on the next rising edge
//   din      in   PAT_W-bit pattern to capture
//   idx      in   bit index to present on bit_out
//   bit_out  out  din bit selected by idx (0 when idx is out of range)
//
// Configuration macro: none (SEQ_GEN_GAP_EN does not affect this block).

module seq_shift_reg #(
  parameter int PAT_W = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [PAT_W-1:0] din,
  input  logic [IDX_W-1:0] idx,
  output logic             bit_out
);

  logic [PAT_W-1:0] data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data <= '0;
    end else if (load) begin
      data <= din;
    end
  end

  // Guard keeps non-power-of-two widths from reading past the top bit.
  always_comb begin
    bit_out = 1'b0;
    if (int'(idx) < PAT_W) begin
      bit_out = data[idx];
    end
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen -- serial test-pattern generator for a sequence detector.
//
// On an accepted start the generator captures pattern/len/reps and emits the
// low len bits of the pattern MSB-first, one bit per clock, repeated reps
// times (reps=0 counts as one). A single-cycle done pulse closes the transfer.
// All outputs are registered, so they show the decision made in the previous
// state: the first bit appears one cycle after busy rises, and done appears
// the cycle after the last bit.
//
// Ports:
//   clk      in   sole clock, rising edge
//   reset    in   asynchronous active-high reset
//   start    in   begin a transfer; honoured only in IDLE
//   abort    in   synchronous cancel; beats start in IDLE
//   pattern  in   PAT_W bits to send (len LSBs used)
//   len      in   bits per repetition; 0 or > PAT_W sends nothing
//   reps     in   repetition count (0 treated as 1)
//   x        out  serial bit, 0 whenever x_valid is low
//   x_valid  out  x carries a pattern bit
//   busy     out  transfer in progress
//   done     out  one-cycle completion pulse
//
// Configuration macro: SEQ_GEN_GAP_EN -- inserts exactly one idle slot
// (x_valid=0, busy=1) between consecutive repetitions. Without it repetitions
// are contiguous, so patterns overlapping across the repetition boundary
// reach the downstream detector.

module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       abort,
  input  logic [PAT_W-1:0]           pattern,
  input  logic [$clog2(PAT_W+1)-1:0] len,
  input  logic [REP_W-1:0]           reps,
  output logic                       x,
  output logic                       x_valid,
  output logic                       busy,
  output logic                       done
);

  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] cnt_next;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_next;
  logic [REP_W-1:0] rep_cnt;
  logic [REP_W-1:0] rep_next;
  logic             load;
  logic             cur_bit;
  logic             x_next;
  logic             x_valid_next;
  logic             busy_next;
  logic             done_next;
  logic             len_bad;

  // cnt never exceeds PAT_W-1 while it is used as an index, so the low
  // IDX_W bits address the whole register.
  seq_shift_reg #(
    .PAT_W (PAT_W),
    .IDX_W (IDX_W)
  ) u_shift_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .din     (pattern),
    .idx     (cnt[IDX_W-1:0]),
    .bit_out (cur_bit)
  );

  assign len_bad = (len == '0) || (len > LEN_W'(PAT_W));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      len_q   <= '0;
      rep_cnt <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      len_q   <= len_next;
      rep_cnt <= rep_next;
      x       <= x_next;
      x_valid <= x_valid_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    len_next     = len_q;
    rep_next     = rep_cnt;
    load         = 1'b0;
    x_next       = 1'b0;
    x_valid_next = 1'b0;
    busy_next    = 1'b0;
    done_next    = 1'b0;

    case (state)
      IDLE: begin
        // abort in IDLE silently drops a simultaneous start.
        if (start && !abort) begin
          load     = 1'b1;
          len_next = len;
          rep_next = (reps == '0) ? REP_W'(1) : reps;
          if (len_bad) begin
            state_next = DONE;
          end else begin
            cnt_next   = len - LEN_W'(1);
            busy_next  = 1'b1;
            state_next = SHIFT;
          end
        end
      end

      SHIFT: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          x_next       = cur_bit;
          x_valid_next = 1'b1;
          busy_next    = 1'b1;
          if (cnt == '0) begin
            if (rep_cnt <= REP_W'(1)) begin
              state_next = DONE;
            end else begin
              rep_next = rep_cnt - REP_W'(1);
`ifdef SEQ_GEN_GAP_EN
              state_next = GAP;
`else
              cnt_next = len_q - LEN_W'(1);
`endif
            end
          end else begin
            cnt_next = cnt - LEN_W'(1);
          end
        end
      end

`ifdef SEQ_GEN_GAP_EN
      GAP: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          busy_next  = 1'b1;
          cnt_next   = len_q - LEN_W'(1);
          state_next = SHIFT;
        end
      end
`endif

      DONE: begin
        // start here is ignored: the FSM only listens in IDLE.
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen -- self-checking bench for seq_pattern_gen.
//
// Build with or without SEQ_GEN_GAP_EN; the reference model follows the same
// macro. Observed outputs are packed as {x, x_valid, busy, done}.

module tb_seq_pattern_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [3:0] len;
  logic [3:0] reps;
  logic       x;
  logic       x_valid;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

`ifdef SEQ_GEN_GAP_EN
  localparam bit GAP_ON = 1'b1;
`else
  localparam bit GAP_ON = 1'b0;
`endif

  always #5 clk = ~clk;

  seq_pattern_gen #(
    .PAT_W (8),
    .REP_W (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .x       (x),
    .x_valid (x_valid),
    .busy    (busy),
    .done    (done)
  );

  function automatic logic [3:0] outs();
    return {x, x_valid, busy, done};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: the per-cycle output trace after an accepted start,
  // derived from the transfer rules (one busy-only cycle, the bits of each
  // repetition MSB-first, optional idle slot between repetitions, done pulse,
  // then idle).
  logic [3:0] expq[$];

  task automatic build(input logic [7:0] pat, input int ln, input int rp, input int abort_at);
    int         er;
    logic [3:0] full[$];
    expq.delete();
    full.delete();
    er = (rp == 0) ? 1 : rp;
    if (ln == 0 || ln > 8) begin
      full.push_back(4'b0000);
      full.push_back(4'b0001);
    end else begin
      full.push_back(4'b0010);
      for (int r = 0; r < er; r++) begin
        for (int i = ln - 1; i >= 0; i--) full.push_back({pat[i], 3'b110});
        if (GAP_ON && r != er - 1) full.push_back(4'b0010);
      end
      full.push_back(4'b0001);
    end
    if (abort_at >= 0) begin
      for (int j = 0; j <= abort_at; j++) expq.push_back(full[j]);
      expq.push_back(4'b0000);
    end else begin
      expq = full;
    end
    expq.push_back(4'b0000);
  endtask

  // Cycle-accurate transfer against the model. Inputs other than start are
  // scrambled once the start has been taken; optional start noise while the
  // generator is active must be ignored.
  task automatic xfer(input logic [7:0] pat, input int ln, input int rp,
                      input int abort_at, input bit noise, input string name);
    int n;
    build(pat, ln, rp, abort_at);
    n = expq.size();
    @(negedge clk);
    pattern = pat;
    len     = 4'(ln);
    reps    = 4'(rp);
    start   = 1'b1;
    abort   = 1'b0;
    @(posedge clk);
    for (int j = 0; j < n; j++) begin
      #1;
      start   = (noise && j < n - 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      abort   = (j == abort_at);
      pattern = 8'($urandom);
      len     = 4'($urandom);
      reps    = 4'($urandom);
      @(negedge clk);
      check($sformatf("%s[%0d]", name, j), 32'(outs()), 32'(expq[j]));
      @(posedge clk);
    end
    #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  pat;
    int          ln;
    int          rp;
    logic [31:0] bits;
    int          nb;
  } vec_t;

  vec_t tbl[7];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         nb;
    int         dones;
    int         gaps;
    int         done_cyc;
    int         cyc;
    int         exp_gaps;
    int         er;
    int         ln;
    int         rp;
    int         ab;
    int         span;
    logic [31:0] got;

    tbl[0] = '{8'h09, 4, 2, 32'b10011001, 8};
    tbl[1] = '{8'h0A, 4, 0, 32'b1010, 4};
    tbl[2] = '{8'h55, 0, 3, 32'b0, 0};
    tbl[3] = '{8'hFF, 9, 1, 32'b0, 0};
    tbl[4] = '{8'hA5, 8, 1, 32'b10100101, 8};
    tbl[5] = '{8'h01, 1, 3, 32'b111, 3};
    tbl[6] = '{8'hF6, 3, 2, 32'b110110, 6};

    reset   = 1'b1;
    start   = 1'b0;
    abort   = 1'b0;
    pattern = 8'h00;
    len     = 4'd0;
    reps    = 4'd0;
    #1;
    check("reset_state", 32'(outs()), 32'h0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Directed table: collect the serial stream and completion timing.
    for (int t = 0; t < 7; t++) begin
      nb       = 0;
      dones    = 0;
      gaps     = 0;
      done_cyc = -1;
      got      = 32'h0;
      er       = (tbl[t].rp == 0) ? 1 : tbl[t].rp;
      exp_gaps = (GAP_ON && tbl[t].nb > 0) ? er - 1 : 0;
      @(negedge clk);
      pattern = tbl[t].pat;
      len     = 4'(tbl[t].ln);
      reps    = 4'(tbl[t].rp);
      start   = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (cyc = 0; cyc < 100; cyc++) begin
        @(negedge clk);
        if (x_valid) begin
          got = {got[30:0], x};
          nb++;
        end else if (busy && nb > 0) begin
          gaps++;
        end
        if (done) begin
          dones++;
          done_cyc = cyc;
        end
        @(posedge clk);
        #1;
        if (dones > 0 && cyc >= done_cyc + 2) break;
      end
      check($sformatf("tbl%0d_bits", t), got, tbl[t].bits);
      check($sformatf("tbl%0d_nbits", t), 32'(nb), 32'(tbl[t].nb));
      check($sformatf("tbl%0d_done_count", t), 32'(dones), 32'd1);
      check($sformatf("tbl%0d_gaps", t), 32'(gaps), 32'(exp_gaps));
      check($sformatf("tbl%0d_done_cycle", t), 32'(done_cyc), 32'(1 + tbl[t].nb + exp_gaps));
    end

    // Cycle-accurate directed transfers.
    xfer(8'h09, 4, 2, -1, 1'b0, "rep2");
    xfer(8'h0A, 4, 0, -1, 1'b0, "reps0");
    xfer(8'h00, 0, 1, -1, 1'b0, "len0");
    xfer(8'hC3, 8, 1, 3, 1'b0, "abort_bit3");
    xfer(8'h09, 4, 2, -1, 1'b1, "busy_start");

    // abort beats start in IDLE.
    @(negedge clk);
    pattern = 8'hFF;
    len     = 4'd8;
    reps    = 4'd1;
    start   = 1'b1;
    abort   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("abort_start_idle[%0d]", j), 32'(outs()), 32'h0);
    end

    // Asynchronous reset during the second repetition.
    @(negedge clk);
    pattern = 8'h09;
    len     = 4'd4;
    reps    = 4'd2;
    start   = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    check("pre_reset_busy", 32'(busy), 32'd1);
    #1 reset = 1'b1;
    #1;
    check("async_reset_outs", 32'(outs()), 32'h0);
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      check($sformatf("reset_held[%0d]", j), 32'(outs()), 32'h0);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    xfer(8'h09, 4, 2, -1, 1'b0, "after_reset");

    // Randomised transfers against the model.
    for (int k = 0; k < 60; k++) begin
      ln = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 9));
      rp = $urandom_range(0, 3);
      er = (rp == 0) ? 1 : rp;
      ab = -1;
      if (ln >= 1 && ln <= 8 && $urandom_range(0, 3) == 0) begin
        span = ln * er + (GAP_ON ? er - 1 : 0);
        ab   = $urandom_range(0, span - 1);
      end
      xfer(8'($urandom), ln, rp, ab, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
